// File: rtl/pipeline_hazard_ctrl_if.sv
// Control interface between the hazard controller and the pipeline registers.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              ex_load;
    logic [REG_AW-1:0] ex_rd;
    logic              branch_taken;
    logic              dmem_busy;
    logic              pc_wen;
    logic              ifid_wen;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              exmem_wen;
    logic              halted;
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;

    // Pipeline side: supplies hazard status, consumes the controls
    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_load, ex_rd, branch_taken, dmem_busy,
        input  pc_wen, ifid_wen, ifid_flush, idex_bubble, exmem_wen,
               halted, stall_cnt, flush_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               ex_load, ex_rd, branch_taken, dmem_busy,
        output pc_wen, ifid_wen, ifid_flush, idex_bubble, exmem_wen,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stall, branch flush,
// memory freeze, memory timeout halt and stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned BR_PENALTY  = 1,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [2:0] PEN = 3'(BR_PENALTY);
    localparam logic [8:0] TMO = 9'(MEM_TIMEOUT);

    state_t            state;
    logic [2:0]        fcnt;
    logic [7:0]        wcnt;
    logic              halted;
    logic [15:0]       stall_cnt;
    logic [15:0]       flush_cnt;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              load_use;
    logic              pc_wen;
    logic              ifid_wen;
    logic              ifid_flush;
    logic              idex_bubble;
    logic              exmem_wen;

    assign id_rs1 = bus.id_rs1;
    assign id_rs2 = bus.id_rs2;
    assign ex_rd  = bus.ex_rd;

    // Load in EX writes a register the ID instruction actually reads (x0 never hazards)
    always_comb begin
        load_use = bus.id_valid & bus.ex_load & (ex_rd != '0) &
                   ((bus.id_use_rs1 & (id_rs1 == ex_rd)) |
                    (bus.id_use_rs2 & (id_rs2 == ex_rd)));
    end

    // Prioritised control decode: reset, halt, freeze, flush, load-use stall, run
    always_comb begin
        pc_wen      = 1'b1;
        ifid_wen    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_wen   = 1'b1;
        if (rst) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            exmem_wen   = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == HALT || bus.dmem_busy) begin
            pc_wen    = 1'b0;
            ifid_wen  = 1'b0;
            exmem_wen = 1'b0;
        end else if (bus.branch_taken || state == FLUSH) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_wen      = 1'b0;
            ifid_wen    = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Controller state: flush countdown, busy watchdog, halt latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            fcnt   <= '0;
            wcnt   <= '0;
            halted <= 1'b0;
        end else if (state != HALT) begin
            if (bus.dmem_busy) begin
                // fcnt holds while frozen; a held branch is applied once busy drops
                if (wcnt != '1) begin
                    wcnt <= wcnt + 8'd1;
                end
                if ({1'b0, wcnt} + 9'd1 == TMO) begin
                    state  <= HALT;
                    halted <= 1'b1;
                end
            end else begin
                wcnt <= '0;
                if (bus.branch_taken) begin
                    if (PEN != '0) begin
                        state <= FLUSH;
                        fcnt  <= PEN;
                    end
                end else if (state == FLUSH) begin
                    if (fcnt == 3'd1) begin
                        state <= RUN;
                    end
                    fcnt <= fcnt - 3'd1;
                end
            end
        end
    end

    // Saturating performance counters, updated after each qualifying cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_wen && state != HALT && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (ifid_flush && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end

    assign bus.pc_wen      = pc_wen;
    assign bus.ifid_wen    = ifid_wen;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_bubble = idex_bubble;
    assign bus.exmem_wen   = exmem_wen;
    assign bus.halted      = halted;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: three configurations driven with the same
// stimulus, each checked against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       idv, u1, u2, ld, br, busy;
    logic [4:0] rs1, rs2, rd;

    int total = 0;
    int bad   = 0;

    // Per-instance configuration: A(pen 1, tmo 4), B(pen 3, tmo 255), C(pen 0, tmo 6)
    int pen [3] = '{1, 3, 0};
    int tmo [3] = '{4, 255, 6};

    // Model state: remaining flush cycles, consecutive busy cycles, halt, counters
    int rem [3];
    int run [3];
    bit hlt [3];
    int stc [3];
    int flc [3];

    logic [4:0]  o_ctl [3];
    logic        o_h   [3];
    logic [15:0] o_st  [3];
    logic [15:0] o_fl  [3];

    pipeline_hazard_ctrl_if #(.REG_AW(5)) ia ();
    pipeline_hazard_ctrl_if #(.REG_AW(5)) ib ();
    pipeline_hazard_ctrl_if #(.REG_AW(5)) ic ();

    pipeline_hazard_ctrl #(.REG_AW(5), .BR_PENALTY(1), .MEM_TIMEOUT(4))
        dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    pipeline_hazard_ctrl #(.REG_AW(5), .BR_PENALTY(3), .MEM_TIMEOUT(255))
        dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    pipeline_hazard_ctrl #(.REG_AW(5), .BR_PENALTY(0), .MEM_TIMEOUT(6))
        dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    assign ia.id_valid = idv;  assign ib.id_valid = idv;  assign ic.id_valid = idv;
    assign ia.id_rs1 = rs1;    assign ib.id_rs1 = rs1;    assign ic.id_rs1 = rs1;
    assign ia.id_rs2 = rs2;    assign ib.id_rs2 = rs2;    assign ic.id_rs2 = rs2;
    assign ia.id_use_rs1 = u1; assign ib.id_use_rs1 = u1; assign ic.id_use_rs1 = u1;
    assign ia.id_use_rs2 = u2; assign ib.id_use_rs2 = u2; assign ic.id_use_rs2 = u2;
    assign ia.ex_load = ld;    assign ib.ex_load = ld;    assign ic.ex_load = ld;
    assign ia.ex_rd = rd;      assign ib.ex_rd = rd;      assign ic.ex_rd = rd;
    assign ia.branch_taken = br; assign ib.branch_taken = br; assign ic.branch_taken = br;
    assign ia.dmem_busy = busy;  assign ib.dmem_busy = busy;  assign ic.dmem_busy = busy;

    assign o_ctl[0] = {ia.pc_wen, ia.ifid_wen, ia.ifid_flush, ia.idex_bubble, ia.exmem_wen};
    assign o_ctl[1] = {ib.pc_wen, ib.ifid_wen, ib.ifid_flush, ib.idex_bubble, ib.exmem_wen};
    assign o_ctl[2] = {ic.pc_wen, ic.ifid_wen, ic.ifid_flush, ic.idex_bubble, ic.exmem_wen};
    assign o_h[0] = ia.halted;     assign o_h[1] = ib.halted;     assign o_h[2] = ic.halted;
    assign o_st[0] = ia.stall_cnt; assign o_st[1] = ib.stall_cnt; assign o_st[2] = ic.stall_cnt;
    assign o_fl[0] = ia.flush_cnt; assign o_fl[1] = ib.flush_cnt; assign o_fl[2] = ic.flush_cnt;

    task automatic chk(input string tag, input int k, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s dut=%0d observed=%h expected=%h", tag, k, o, e);
        end
    endtask

    task automatic idle();
        idv = 0; u1 = 0; u2 = 0; ld = 0; br = 0; busy = 0;
        rs1 = 0; rs2 = 0; rd = 0;
    endtask

    // One cycle: check controls and registered outputs, then advance the model
    task automatic step();
        bit lu;
        logic [4:0] e [3];
        #1;
        lu = idv && ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        for (int k = 0; k < 3; k++) begin
            // {pc_wen, ifid_wen, ifid_flush, idex_bubble, exmem_wen}
            if (rst)                    e[k] = 5'b00110;
            else if (hlt[k] || busy)    e[k] = 5'b00000;
            else if (br || rem[k] > 0)  e[k] = 5'b11111;
            else if (lu)                e[k] = 5'b00011;
            else                        e[k] = 5'b11001;
            chk("ctl", k, 16'(o_ctl[k]), 16'(e[k]));
            chk("halted", k, 16'(o_h[k]), 16'(hlt[k]));
            chk("stall_cnt", k, o_st[k], 16'(stc[k]));
            chk("flush_cnt", k, o_fl[k], 16'(flc[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rem[k] = 0; run[k] = 0; hlt[k] = 0; stc[k] = 0; flc[k] = 0;
            end else begin
                if (!e[k][4] && !hlt[k] && stc[k] < 65535) stc[k]++;
                if (e[k][2] && flc[k] < 65535) flc[k]++;
                if (!hlt[k]) begin
                    if (busy) begin
                        run[k]++;
                        if (run[k] == tmo[k]) hlt[k] = 1;
                    end else begin
                        run[k] = 0;
                        if (br)              rem[k] = pen[k];
                        else if (rem[k] > 0) rem[k]--;
                    end
                end
            end
        end
        #1;
    endtask

    initial begin
        idle();
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0; run[k] = 0; hlt[k] = 0; stc[k] = 0; flc[k] = 0;
        end
        @(posedge clk); #1;

        // Reset pattern
        rst = 1; step(); step();
        rst = 0;

        // Load-use on rs2, then bubble in EX
        idv = 1; ld = 1; rd = 5; u2 = 1; rs2 = 5; step();
        ld = 0; step();
        chk("lu_stall_once", 0, o_st[0], 16'd1);

        // x0 destination, then unused operand
        ld = 1; rd = 0; u1 = 1; rs1 = 0; u2 = 0; step();
        rd = 7; rs1 = 7; u1 = 0; step();
        chk("no_stall_x0_unused", 0, o_st[0], 16'd1);

        // Taken branch pulse
        idle(); br = 1; step();
        br = 0; for (int i = 0; i < 4; i++) step();
        chk("branch_flush_a", 0, o_fl[0], 16'd2);

        // Branch held through a 3-cycle freeze, with load-use inputs present
        busy = 1; br = 1; idv = 1; ld = 1; rd = 3; u1 = 1; rs1 = 3;
        for (int i = 0; i < 3; i++) step();
        busy = 0; step();
        idle(); for (int i = 0; i < 4; i++) step();

        // Reset in the second flush cycle
        br = 1; step();
        br = 0; rst = 1; step();
        rst = 0; for (int i = 0; i < 3; i++) step();

        // Memory timeout (halts A only)
        busy = 1; for (int i = 0; i < 4; i++) step();
        busy = 0; for (int i = 0; i < 3; i++) step();
        chk("timeout_halt_a", 0, 16'(o_h[0]), 16'd1);
        rst = 1; step();
        rst = 0; step();

        // Randomised traffic over a small register space
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(63) == 0);
            busy = ($urandom_range(5) == 0);
            br   = ($urandom_range(5) == 0);
            idv  = $urandom_range(1);
            ld   = $urandom_range(1);
            u1   = $urandom_range(1);
            u2   = $urandom_range(1);
            rd   = 5'($urandom_range(7));
            rs1  = 5'($urandom_range(7));
            rs2  = 5'($urandom_range(7));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
